// File: rtl/axil_apb_bridge_if.sv
// AXI4-Lite and APB3 bus bundles used by the AXI4-Lite to APB3 bridge.

interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int DATA_BYTE_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0]      awaddr;
    logic [2:0]                 awprot;
    logic                       awvalid;
    logic                       awready;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [DATA_BYTE_WIDTH-1:0] wstrb;
    logic                       wvalid;
    logic                       wready;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;
    logic [ADDR_WIDTH-1:0]      araddr;
    logic [2:0]                 arprot;
    logic                       arvalid;
    logic                       arready;
    logic [DATA_WIDTH-1:0]      rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface apb3_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVE  = 4
);
    logic [NUM_SLAVE-1:0]  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/axil_apb_bridge.sv
// AXI4-Lite target to APB3 initiator bridge: one transaction in flight, address
// decode, strobe check, APB wait states, ready timeout and saturating error count.

module axil_apb_bridge #(
    parameter int NUM_SLAVE       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        rst,
    axi4_lite_if.slave  s_axil,
    apb3_if.master      m_apb,
    output logic [15:0] err_count
);
    localparam int SEL_W    = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1;
    localparam int TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WRESP, S_RRESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_write;
    logic [1:0]            r_resp;
    logic                  r_prio_wr;
    logic [TMO_W-1:0]      r_tmo;
    logic [15:0]           r_err_cnt;

    logic                  w_idle;
    logic                  w_wr_elig;
    logic                  w_rd_elig;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic                  w_decerr;
    logic                  w_strb_err;
    logic                  w_tmo;
    logic                  w_access_done;
    logic                  w_resp_hs;
    logic                  w_unused_prot;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Out of range when any bit above the select field is set or the index has no peripheral.
    function automatic logic decode_err(input logic [ADDR_WIDTH-1:0] a);
        logic [SEL_W:0] idx;
        idx = {1'b0, a[SLAVE_ADDR_BITS +: SEL_W]};
        return ((a >> (SLAVE_ADDR_BITS + SEL_W)) != '0) || (idx >= (SEL_W+1)'(NUM_SLAVE));
    endfunction

    assign w_unused_prot = ^{s_axil.awprot, s_axil.arprot};

    assign w_idle        = (r_state == S_IDLE);
    assign w_wr_elig     = w_idle && s_axil.awvalid && s_axil.wvalid;
    assign w_rd_elig     = w_idle && s_axil.arvalid;
    assign w_grant_wr    = w_wr_elig && (!w_rd_elig || r_prio_wr);
    assign w_grant_rd    = w_rd_elig && !w_grant_wr;
    assign w_accept      = w_grant_wr || w_grant_rd;
    assign w_acc_addr    = w_grant_wr ? s_axil.awaddr : s_axil.araddr;
    assign w_decerr      = decode_err(w_acc_addr);
    assign w_strb_err    = w_grant_wr && (s_axil.wstrb != '1);
    assign w_tmo         = (TIMEOUT_CYCLES != 0) && (r_tmo == TMO_W'(TMO_LAST));
    assign w_access_done = (r_state == S_ACCESS) && (m_apb.pready || w_tmo);
    assign w_resp_hs     = ((r_state == S_WRESP) && s_axil.bready) ||
                           ((r_state == S_RRESP) && s_axil.rready);
    assign err_count     = r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_decerr || w_strb_err) w_next = w_grant_wr ? S_WRESP : S_RRESP;
                    else                        w_next = S_SETUP;
                end
            end
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (w_access_done) w_next = r_write ? S_WRESP : S_RRESP;
            S_WRESP:  if (s_axil.bready) w_next = S_IDLE;
            S_RRESP:  if (s_axil.rready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_axil.awready = w_grant_wr;
        s_axil.wready  = w_grant_wr;
        s_axil.arready = w_grant_rd;
        s_axil.bvalid  = (r_state == S_WRESP);
        s_axil.bresp   = (r_state == S_WRESP) ? r_resp : 2'b00;
        s_axil.rvalid  = (r_state == S_RRESP);
        s_axil.rresp   = (r_state == S_RRESP) ? r_resp : 2'b00;
        s_axil.rdata   = (r_state == S_RRESP) ? r_rdata : '0;
        m_apb.psel     = '0;
        if ((r_state == S_SETUP) || (r_state == S_ACCESS))
            m_apb.psel = NUM_SLAVE'(1) << r_addr[SLAVE_ADDR_BITS +: SEL_W];
        m_apb.penable  = (r_state == S_ACCESS);
        m_apb.paddr    = r_addr;
        m_apb.pwrite   = r_write;
        m_apb.pwdata   = r_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_write   <= 1'b0;
            r_resp    <= RESP_OKAY;
            r_prio_wr <= 1'b1;
            r_tmo     <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_addr    <= w_acc_addr;
                r_wdata   <= s_axil.wdata;
                r_write   <= w_grant_wr;
                r_prio_wr <= !w_grant_wr;
                r_rdata   <= '0;
                r_tmo     <= '0;
                r_resp    <= w_decerr ? RESP_DECERR : (w_strb_err ? RESP_SLVERR : RESP_OKAY);
            end
            if (r_state == S_ACCESS) begin
                if (m_apb.pready) begin
                    r_resp  <= m_apb.pslverr ? RESP_SLVERR : RESP_OKAY;
                    r_rdata <= m_apb.pslverr ? '0 : m_apb.prdata;
                end else if (w_tmo) begin
                    r_resp  <= RESP_SLVERR;
                    r_rdata <= '0;
                end else begin
                    r_tmo   <= r_tmo + TMO_W'(1);
                end
            end
            if (w_resp_hs && (r_resp != RESP_OKAY))
                r_err_cnt <= sat_inc(r_err_cnt);
        end
    end
endmodule

// File: tb/tb_axil_apb_bridge.sv
// Scoreboard bench for axil_apb_bridge: directed stimulus pushes expectations,
// a negedge monitor pops and compares APB setups and AXI responses.

module tb_axil_apb_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] err_count;

    axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();
    apb3_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVE(4)) apb ();

    axil_apb_bridge #(
        .NUM_SLAVE(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .SLAVE_ADDR_BITS(12), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .s_axil(axil), .m_apb(apb), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;
        logic [15:0] errc;
    } rsp_t;

    typedef struct {
        logic [3:0]  psel;
        logic [31:0] paddr;
        bit          pwrite;
        logic [31:0] pwdata;
        int          n_acc;
    } apb_t;

    rsp_t  sb_q[$];
    apb_t  apb_q[$];
    int    acc_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_setups = 0;
    int    exp_setups = 0;

    // APB peripheral model
    int          cfg_wait = 0;
    bit          cfg_hang = 0;
    bit          cfg_err = 0;
    logic [31:0] cfg_rdata = '0;
    int          acc_cnt = 0;

    assign apb.pready  = apb.penable && !cfg_hang && (acc_cnt == cfg_wait);
    assign apb.prdata  = cfg_rdata;
    assign apb.pslverr = cfg_err && apb.pready;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        acc_cnt <= apb.penable ? acc_cnt + 1 : 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    bit          in_apb = 0;
    int          n_acc = 0;
    apb_t        cur;
    bit          prev_bv = 0;
    bit          prev_rv = 0;
    bit          err_pend = 0;
    logic [15:0] err_exp = '0;

    task automatic handle_rsp(input bit is_wr);
        rsp_t e;
        int   a;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got %s response, expected none", is_wr ? "write" : "read");
            return;
        end
        e = sb_q.pop_front();
        check("rsp_kind_is_write", is_wr, e.is_wr);
        check(is_wr ? "bresp" : "rresp", is_wr ? axil.bresp : axil.rresp, e.resp);
        if (!is_wr) check("rdata", axil.rdata, e.rdata);
        if (acc_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_latency: got response with no recorded accept, expected one");
        end else begin
            a = acc_q.pop_front();
            check("rsp_latency", cyc - a, e.lat);
        end
        err_exp  = e.errc;
        err_pend = 1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            in_apb   = 0;
            prev_bv  = 0;
            prev_rv  = 0;
            err_pend = 0;
        end else begin
            if (err_pend) begin
                check("err_count", err_count, err_exp);
                err_pend = 0;
            end
            if (axil.awvalid && axil.awready) acc_q.push_back(cyc);
            if (axil.arvalid && axil.arready) acc_q.push_back(cyc);
            if (apb.psel != 0 && !apb.penable) begin
                n_setups++;
                if (apb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_setup: got psel 0x%0h, expected none", apb.psel);
                end else begin
                    cur = apb_q.pop_front();
                    check("psel", apb.psel, cur.psel);
                    check("paddr", apb.paddr, cur.paddr);
                    check("pwrite", apb.pwrite, cur.pwrite);
                    if (cur.pwrite) check("pwdata", apb.pwdata, cur.pwdata);
                    in_apb = 1;
                    n_acc  = 0;
                end
            end else if (apb.penable) begin
                n_acc++;
            end else if (in_apb) begin
                check("access_cycles", n_acc, cur.n_acc);
                check("psel_after_access", apb.psel, 4'b0000);
                in_apb = 0;
            end
            if (axil.bvalid && !prev_bv) handle_rsp(1'b1);
            if (axil.rvalid && !prev_rv) handle_rsp(1'b0);
            prev_bv = axil.bvalid;
            prev_rv = axil.rvalid;
        end
    end

    // Stimulus helpers (all entered and left at posedge + 1)
    task automatic push_apb(input logic [3:0] ps, input logic [31:0] pa, input bit pw,
                            input logic [31:0] pd, input int na);
        apb_t e;
        e.psel = ps; e.paddr = pa; e.pwrite = pw; e.pwdata = pd; e.n_acc = na;
        apb_q.push_back(e);
        exp_setups++;
    endtask

    task automatic push_rsp(input bit w, input logic [1:0] r, input logic [31:0] d,
                            input int l, input logic [15:0] ec);
        rsp_t e;
        e.is_wr = w; e.resp = r; e.rdata = d; e.lat = l; e.errc = ec;
        sb_q.push_back(e);
    endtask

    task automatic wait_accept(input bit wr);
        bit got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = wr ? axil.awready : axil.arready;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no %s ready within 50 cycles, expected ready", wr ? "aw" : "ar");
        end
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        axil.awaddr = a; axil.wdata = d; axil.wstrb = s;
        axil.awvalid = 1; axil.wvalid = 1;
        wait_accept(1'b1);
        axil.awvalid = 0; axil.wvalid = 0;
    endtask

    task automatic do_read(input logic [31:0] a);
        axil.araddr = a; axil.arvalid = 1;
        wait_accept(1'b0);
        axil.arvalid = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (sb_q.size() != 0 || apb_q.size() != 0 || in_apb); k++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("rsp_queue_drained", sb_q.size(), 0);
    endtask

    initial begin
        int n;
        rst = 1;
        axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 0;
        axil.wdata = '0; axil.wstrb = '0; axil.wvalid = 0;
        axil.araddr = '0; axil.arprot = '0; axil.arvalid = 0;
        axil.bready = 1; axil.rready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_apb_outputs", {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, '0);
        check("reset_axi_outputs", {axil.awready, axil.wready, axil.arready, axil.bvalid, axil.rvalid,
                                    axil.bresp, axil.rresp, axil.rdata}, '0);
        check("reset_err_count", err_count, 16'h0000);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // Zero-wait write to peripheral 1
        push_apb(4'b0010, 32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 1);
        push_rsp(1'b1, 2'b00, '0, 3, 16'd0);
        do_write(32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
        drain();

        // Read with three wait states from peripheral 2
        cfg_wait = 3; cfg_rdata = 32'h1234_5678;
        push_apb(4'b0100, 32'h0000_2010, 1'b0, '0, 4);
        push_rsp(1'b0, 2'b00, 32'h1234_5678, 6, 16'd0);
        do_read(32'h0000_2010);
        drain();

        // Decode error, strobe error, slave error
        cfg_wait = 0;
        push_rsp(1'b1, 2'b11, '0, 1, 16'd1);
        do_write(32'h0001_0000, 32'h0000_0001, 4'hF);
        drain();
        push_rsp(1'b1, 2'b10, '0, 1, 16'd2);
        do_write(32'h0000_3000, 32'h0000_ABCD, 4'h3);
        drain();
        cfg_err = 1; cfg_rdata = 32'hAAAA_5555;
        push_apb(4'b0001, 32'h0000_0008, 1'b0, '0, 1);
        push_rsp(1'b0, 2'b10, '0, 3, 16'd3);
        do_read(32'h0000_0008);
        drain();
        cfg_err = 0;

        // Arbitration: write pair and read held together for four grants
        cfg_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 2; i++) begin
            push_apb(4'b0010, 32'h0000_1000, 1'b1, 32'h1111_1111, 1);
            push_rsp(1'b1, 2'b00, '0, 3, 16'd3);
            push_apb(4'b0100, 32'h0000_2000, 1'b0, '0, 1);
            push_rsp(1'b0, 2'b00, 32'hCAFE_F00D, 3, 16'd3);
        end
        axil.awaddr = 32'h0000_1000; axil.wdata = 32'h1111_1111; axil.wstrb = 4'hF;
        axil.araddr = 32'h0000_2000;
        axil.awvalid = 1; axil.wvalid = 1; axil.arvalid = 1;
        n = 0;
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(negedge clk);
            if (axil.awready || axil.arready) n++;
        end
        @(posedge clk); #1;
        axil.awvalid = 0; axil.wvalid = 0; axil.arvalid = 0;
        check("arb_grant_count", n, 4);
        drain();

        // Ready timeout on peripheral 3
        cfg_hang = 1;
        push_apb(4'b1000, 32'h0000_3FFC, 1'b0, '0, 16);
        push_rsp(1'b0, 2'b10, '0, 18, 16'd4);
        do_read(32'h0000_3FFC);
        drain();

        // Reset during ACCESS discards the transaction
        push_apb(4'b0010, 32'h0000_1008, 1'b1, 32'h0000_0055, 0);
        do_write(32'h0000_1008, 32'h0000_0055, 4'hF);
        n = 0;
        for (int k = 0; k < 20 && n == 0; k++) begin
            @(negedge clk);
            if (apb.penable) n = 1;
        end
        check("reached_access", n, 1);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("rst_psel_penable", {apb.psel, apb.penable}, 5'b0);
        check("rst_err_count", err_count, 16'h0000);
        @(posedge clk); #1;
        rst = 0;
        cfg_hang = 0;
        repeat (10) @(posedge clk);
        #1;
        check("no_rsp_after_reset", {axil.bvalid, axil.rvalid}, 2'b00);

        push_apb(4'b0010, 32'h0000_1008, 1'b1, 32'h600D_F00D, 1);
        push_rsp(1'b1, 2'b00, '0, 3, 16'd0);
        do_write(32'h0000_1008, 32'h600D_F00D, 4'hF);
        drain();

        check("apb_setup_count", n_setups, exp_setups);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/axil_apb_bridge.md
# axil_apb_bridge

- Bridges one AXI4-Lite target port (`axi4_lite_if.slave`) to one APB3 initiator port (`apb3_if.master`) that drives `NUM_SLAVE` peripherals.
- Sits directly downstream of the AXI4-Lite register bus and directly upstream of the APB3 peripheral fabric. It is the only producer of `apb3_if` traffic in the control path.
- Handles one transaction at a time.
- Performs address decode, byte-strobe checking, APB wait-state handling and a ready timeout, and keeps a saturating error counter.

## Interface

Parameters:
- `NUM_SLAVE`, 4: number of APB peripherals; width of `psel`.
- `ADDR_WIDTH`, 32: AXI and APB address width.
- `DATA_WIDTH`, 32: data width; the AXI `DATA_BYTE_WIDTH` equals `DATA_WIDTH/8`.
- `SLAVE_ADDR_BITS`, 12: each peripheral owns a window of 2^`SLAVE_ADDR_BITS` bytes.
- `TIMEOUT_CYCLES`, 256: maximum number of ACCESS cycles to wait for `pready`; 0 disables the timeout.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `s_axil`, `axi4_lite_if.slave`, bundle: AXI4-Lite target. `awprot` and `arprot` are ignored.
- `m_apb`, `apb3_if.master`, bundle: APB3 initiator; `psel` is `NUM_SLAVE` bits wide.
- `err_count`, output, 16: saturating count of completed responses whose resp is not OKAY.

## Operation

Derived quantities:
- `SEL_W` = max(1, clog2(`NUM_SLAVE`)).
- Slave index `idx` = `addr[SLAVE_ADDR_BITS +: SEL_W]`.

Decode error (DECERR): the address decodes to DECERR when either
- any address bit at or above `SLAVE_ADDR_BITS+SEL_W` is 1, or
- `idx` is greater than or equal to `NUM_SLAVE`.

State machine states: IDLE, SETUP, ACCESS, WRESP, RRESP.

IDLE:
- A write is eligible only when `awvalid` and `wvalid` are both high. AW and W are accepted together: `awready` and `wready` go high in the same cycle.
- A read is eligible when `arvalid` is high.
- If a write and a read are both eligible, round-robin priority applies. After reset the write wins; after that, the grant goes to the type not served last.
- Ready signals are combinational: for example, `awready` = (state==IDLE) && `awvalid` && `wvalid` && grant_write. `arready` is formed the same way with the read grant.
- The accept cycle captures the address, `wdata`, `wstrb` and the direction.

Error short-cuts (no APB cycle is issued):
- Decode error: go straight to WRESP or RRESP with resp 2'b11.
- Write with `wstrb` not all-ones: go straight to WRESP with resp 2'b10, because APB3 has no byte strobes.

SETUP (one cycle):
- `psel[idx]`=1, `penable`=0.
- `paddr` = captured address.
- `pwrite` = 1 for writes, 0 for reads.
- `pwdata` = captured data.

ACCESS:
- `penable`=1; `psel`, `paddr`, `pwrite` and `pwdata` hold their SETUP values.
- When `pready` is high, sample `pslverr` and `prdata`. Resp is 2'b10 if `pslverr`, otherwise 2'b00.
- Timeout: if `TIMEOUT_CYCLES`≠0 and `pready` has stayed low for `TIMEOUT_CYCLES` ACCESS cycles, abort with resp 2'b10 and `rdata`=0.
- After the completing cycle, `psel` and `penable` drop to 0 and the state moves to WRESP or RRESP.

WRESP:
- `bvalid`=1 with the stored `bresp`, held stable until `bready`.

RRESP:
- `rvalid`=1 with `rresp` and `rdata`, held stable until `rready`.
- `rdata` is 0 for any response that is not OKAY.

Response handshake: when it completes, the state returns to IDLE and `err_count` increments if resp≠2'b00. The counter saturates at 16'hFFFF.

## Timing

Reset values:
- All outputs are 0: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, all ready signals, `bvalid`, `rvalid`, `bresp`, `rresp`, `rdata`, `err_count`.
- The state is IDLE and the priority flag selects write.

Cycle-level behaviour (accept cycle = T):
- APB access: SETUP at T+1, ACCESS at T+2.
- Zero-wait APB: response valid at T+3. Each wait state adds one cycle.
- Error short-cut: response valid at T+1.
- If the master holds the response ready high, the block is back in IDLE one cycle after the response appears, so the next accept is possible at T+4 (APB) or T+2 (short-cut).
- No ready is asserted outside IDLE, so there is never a second outstanding transaction.

Reset mid-operation:
- `psel` and `penable` drop immediately.
- The pending transaction is discarded and no response is issued.
- `err_count` clears.

## Test plan

- Write, zero wait states: address 0x0000_1004, data 0xDEADBEEF, `wstrb` 0xF, `pready` held high → `psel`=4'b0010 and `paddr`=0x1004 at T+1; `penable`=1 at T+2; `bvalid` with `bresp`=00 at T+3; `err_count`=0.
- Read with 3 wait states: address 0x0000_2010, `pready` goes high on the 4th ACCESS cycle, `prdata`=0x12345678 → `rvalid` at T+6 with `rdata`=0x12345678 and `rresp`=00.
- Error responses:
  - Address 0x0001_0000 → no `psel`, `bresp`=11 at T+1, `err_count`=1.
  - Then `wstrb`=0x3 → no `psel`, `bresp`=10, `err_count`=2.
  - Then `pslverr`=1 on a read → `rresp`=10, `err_count`=3.
- Arbitration: write pair and read held valid together for 4 transactions → grants issued in the order W, R, W, R.
- Timeout: `TIMEOUT_CYCLES`=16, `pready` tied low → exactly 16 ACCESS cycles; then `psel`=0 and the read returns `rresp`=10 with `rdata`=0.
- Reset mid-operation: assert `rst` during ACCESS → `psel` and `penable` are 0 in that same cycle and no response is issued. A following write completes normally with `bresp`=00.
